dmem_mmio: RTL and testbench

- Memory-side responder for the single-cycle ARM core's data port.
- The core drives address (ALUResult), WriteData and MemWrite, and samples ReadData in the same cycle.
- The block decodes the address into word RAM or a small memory-mapped peripheral window used by the Flappy Bird game:
  - flap button capture
  - periodic frame timer
  - LFSR for pipe heights
  - LED/debug output register

---
 rtl/dmem_mmio_pkg.sv | 19 +
 rtl/dmem_mmio_if.sv | 10 +
 rtl/dmem_mmio_frame_timer.sv | 48 ++++
 rtl/dmem_mmio.sv | 101 ++++++++++
 tb/tb_dmem_mmio.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared offsets, LFSR taps and step function for dmem_mmio
package dmem_mmio_pkg;

  localparam logic [5:0] OFF_BTN_STATUS = 6'h00;
  localparam logic [5:0] OFF_BTN_RAW    = 6'h04;
  localparam logic [5:0] OFF_TMR_CTRL   = 6'h08;
  localparam logic [5:0] OFF_TMR_PERIOD = 6'h0C;
  localparam logic [5:0] OFF_TMR_STATUS = 6'h10;
  localparam logic [5:0] OFF_LFSR       = 6'h14;
  localparam logic [5:0] OFF_LED        = 6'h18;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// rtl/dmem_mmio_if.sv - core data-port bus between the ARM core and dmem_mmio
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output Addr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input Addr, input WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio_frame_timer.sv
// rtl/dmem_mmio_frame_timer.sv - reloading down-counter with sticky tick flag
module frame_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_ctrl,
  input  logic        i_we_period,
  input  logic        i_clr_tick,
  input  logic [31:0] i_wdata,
  output logic        o_enable,
  output logic [31:0] o_period,
  output logic [30:0] o_count,
  output logic        o_tick
);

  logic        r_enable;
  logic [31:0] r_period;
  logic [31:0] r_count;
  logic        r_tick;
  logic        w_reload;

  assign w_reload = r_enable && (r_count == 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_period <= '0;
      r_count  <= '0;
      r_tick   <= 1'b0;
    end else begin
      if (i_we_ctrl)   r_enable <= i_wdata[0];
      if (i_we_period) r_period <= i_wdata;

      // A period write reloads the counter immediately, beating decrement and reload.
      if (i_we_period)   r_count <= i_wdata;
      else if (w_reload) r_count <= r_period;
      else if (r_enable) r_count <= r_count - 32'd1;

      if (w_reload)        r_tick <= 1'b1;
      else if (i_clr_tick) r_tick <= 1'b0;
    end
  end

  assign o_enable = r_enable;
  assign o_period = r_period;
  assign o_count  = r_count[30:0];
  assign o_tick   = r_tick;

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data memory plus Flappy Bird peripheral window (button, timer, LFSR, LED)
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = 32'h0000_2000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  dmem_mmio_if.slave      bus,
  input  logic            btn_flap,
  output logic [7:0]      led
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic        r_sync0, r_sync1, r_sync_prev, r_flap;
  logic [15:0] r_lfsr;
  logic [7:0]  r_led;

  logic        w_ram_hit, w_io_hit, w_io_wr, w_btn_edge;
  logic [5:0]  w_off;
  logic [AW-1:0] w_idx;
  logic        w_tmr_enable, w_tmr_tick;
  logic [31:0] w_tmr_period;
  logic [30:0] w_tmr_count;
  logic [31:0] w_rdata;

  assign w_ram_hit  = bus.Addr < 32'(RAM_WORDS * 4);
  assign w_io_hit   = bus.Addr[31:6] == IO_BASE[31:6];
  assign w_off      = {bus.Addr[5:2], 2'b00};
  assign w_idx      = bus.Addr[AW+1:2];
  assign w_io_wr    = bus.MemWrite && w_io_hit;
  assign w_btn_edge = r_sync1 && !r_sync_prev;

  always_ff @(posedge clk) begin
    if (bus.MemWrite && w_ram_hit) r_ram[w_idx] <= bus.WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0     <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_flap      <= 1'b0;
      r_lfsr      <= LFSR_SEED;
      r_led       <= '0;
    end else begin
      r_sync0     <= btn_flap;
      r_sync1     <= r_sync0;
      r_sync_prev <= r_sync1;
      if (w_btn_edge)
        r_flap <= 1'b1;
      else if (w_io_wr && w_off == OFF_BTN_STATUS && bus.WriteData[0])
        r_flap <= 1'b0;
      // Zero would lock the LFSR up, so a zero seed falls back to LFSR_SEED.
      if (w_io_wr && w_off == OFF_LFSR)
        r_lfsr <= (bus.WriteData[15:0] == 16'd0) ? LFSR_SEED : bus.WriteData[15:0];
      else
        r_lfsr <= lfsr_next(r_lfsr);
      if (w_io_wr && w_off == OFF_LED) r_led <= bus.WriteData[7:0];
    end
  end

  frame_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_we_ctrl   (w_io_wr && w_off == OFF_TMR_CTRL),
    .i_we_period (w_io_wr && w_off == OFF_TMR_PERIOD),
    .i_clr_tick  (w_io_wr && w_off == OFF_TMR_STATUS && bus.WriteData[0]),
    .i_wdata     (bus.WriteData),
    .o_enable    (w_tmr_enable),
    .o_period    (w_tmr_period),
    .o_count     (w_tmr_count),
    .o_tick      (w_tmr_tick)
  );

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = r_ram[w_idx];
    end else if (w_io_hit) begin
      case (w_off)
        OFF_BTN_STATUS: w_rdata = {31'd0, r_flap};
        OFF_BTN_RAW:    w_rdata = {31'd0, r_sync1};
        OFF_TMR_CTRL:   w_rdata = {31'd0, w_tmr_enable};
        OFF_TMR_PERIOD: w_rdata = w_tmr_period;
        OFF_TMR_STATUS: w_rdata = {w_tmr_count, w_tmr_tick};
        OFF_LFSR:       w_rdata = {16'd0, r_lfsr};
        OFF_LED:        w_rdata = {24'd0, r_led};
        default:        w_rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = w_rdata;
  assign led          = r_led;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed self-checking bench for dmem_mmio
module tb_dmem_mmio;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_flap = 1'b0;
  logic [7:0] led;
  int         n_checks = 0;
  int         n_fail = 0;

  localparam logic [31:0] A_BTN_STATUS = 32'h2000;
  localparam logic [31:0] A_BTN_RAW    = 32'h2004;
  localparam logic [31:0] A_CTRL       = 32'h2008;
  localparam logic [31:0] A_PERIOD     = 32'h200C;
  localparam logic [31:0] A_TSTAT      = 32'h2010;
  localparam logic [31:0] A_LFSR       = 32'h2014;
  localparam logic [31:0] A_LED        = 32'h2018;

  dmem_mmio_if bus ();

  dmem_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .btn_flap (btn_flap),
    .led      (led)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr      = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    step();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.Addr = a;
    #1;
    d = bus.ReadData;
    check_eq(tag, d, exp);
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    #25;
    rd_chk("rst_led", A_LED, 32'h0);
    rd_chk("rst_tstat", A_TSTAT, 32'h0);
    rd_chk("rst_btn", A_BTN_STATUS, 32'h0);
    check_eq("rst_led_port", {24'd0, led}, 32'h0);
    reset = 1'b0;
    rd_chk("lfsr_seed", A_LFSR, 32'h0000_ACE1);
    step();
    rd_chk("lfsr_step1", A_LFSR, 32'h0000_E270);

    wr(A_LFSR, 32'h0);
    rd_chk("lfsr_zero_seed", A_LFSR, 32'h0000_ACE1);
    wr(A_LFSR, 32'h0001);
    rd_chk("lfsr_load1", A_LFSR, 32'h0000_0001);
    step();
    rd_chk("lfsr_after1", A_LFSR, 32'h0000_B400);

    wr(32'h14, 32'h1234_5678);
    wr(32'h10, 32'hDEAD_BEEF);
    rd_chk("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd_chk("ram_14", 32'h14, 32'h1234_5678);
    bus.Addr = 32'h10; bus.WriteData = 32'hCAFE_0000; bus.MemWrite = 1'b1;
    #1;
    check_eq("ram_old_before_edge", bus.ReadData, 32'hDEAD_BEEF);
    step();
    bus.MemWrite = 1'b0;
    rd_chk("ram_new", 32'h10, 32'hCAFE_0000);
    rd_chk("unmapped_rd", 32'h3000, 32'h0);
    wr(32'h3000, 32'hFFFF_FFFF);
    rd_chk("unmapped_led", A_LED, 32'h0);
    rd_chk("unmapped_ram", 32'h10, 32'hCAFE_0000);
    rd_chk("unmapped_ctrl", A_CTRL, 32'h0);
    rd_chk("off_3c", 32'h203C, 32'h0);

    btn_flap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_chk($sformatf("btn_raw_c%0d", i), A_BTN_RAW, (i >= 2) ? 32'h1 : 32'h0);
      rd_chk($sformatf("btn_pend_c%0d", i), A_BTN_STATUS, (i >= 3) ? 32'h1 : 32'h0);
      step();
    end
    rd_chk("alias_2003", 32'h2003, 32'h1);
    wr(A_BTN_STATUS, 32'h1);
    rd_chk("btn_cleared", A_BTN_STATUS, 32'h0);
    step(); step(); step();
    rd_chk("btn_held_clear", A_BTN_STATUS, 32'h0);
    wr(A_BTN_RAW, 32'h0);
    rd_chk("btn_raw_ro", A_BTN_RAW, 32'h1);
    btn_flap = 1'b0;
    step(); step(); step();
    btn_flap = 1'b1;
    step(); step();
    wr(A_BTN_STATUS, 32'h1);
    rd_chk("btn_set_wins", A_BTN_STATUS, 32'h1);
    wr(A_BTN_STATUS, 32'h1);
    rd_chk("btn_clear2", A_BTN_STATUS, 32'h0);
    btn_flap = 1'b0;

    wr(A_PERIOD, 32'd3);
    wr(A_CTRL, 32'd1);
    for (int k = 0; k < 5; k++) begin
      rd_chk($sformatf("tmr_k%0d", k), A_TSTAT,
             (k < 4) ? ((32'd3 - 32'(k)) << 1) : 32'h7);
      if (k < 4) step();
    end
    wr(A_CTRL, 32'd0);
    rd_chk("tmr_dis", A_TSTAT, 32'h5);
    step(); step(); step();
    rd_chk("tmr_hold", A_TSTAT, 32'h5);
    rd_chk("tmr_ctrl_rd", A_CTRL, 32'h0);
    wr(A_TSTAT, 32'h1);
    rd_chk("tmr_clr", A_TSTAT, 32'h4);
    wr(A_CTRL, 32'd1);
    step(); step();
    rd_chk("tmr_at0", A_TSTAT, 32'h0);
    wr(A_TSTAT, 32'h1);
    rd_chk("tmr_clr_vs_reload", A_TSTAT, 32'h7);
    wr(A_PERIOD, 32'd0);
    rd_chk("tmr_p0_load", A_TSTAT, 32'h1);
    wr(A_TSTAT, 32'h1);
    rd_chk("tmr_p0_tick", A_TSTAT, 32'h1);
    rd_chk("tmr_period_rd", A_PERIOD, 32'h0);

    btn_flap = 1'b1;
    wr(A_LED, 32'h0000_00A5);
    step(); step();
    wr(A_PERIOD, 32'd5);
    rd_chk("pre_tstat", A_TSTAT, 32'd11);
    rd_chk("pre_led", A_LED, 32'hA5);
    check_eq("pre_led_port", {24'd0, led}, 32'hA5);
    rd_chk("pre_btn", A_BTN_STATUS, 32'h1);
    #3;
    reset = 1'b1;
    rd_chk("mid_led", A_LED, 32'h0);
    rd_chk("mid_tstat", A_TSTAT, 32'h0);
    rd_chk("mid_btn", A_BTN_STATUS, 32'h0);
    rd_chk("mid_lfsr", A_LFSR, 32'h0000_ACE1);
    check_eq("mid_led_port", {24'd0, led}, 32'h0);
    btn_flap = 1'b0;
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
